// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and duty clamp helper for pwm_gen
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    PEND = 2'b10
  } pwm_state_t;

  // Requested high-time can never exceed a full period.
  function automatic int unsigned clamp_duty(input int unsigned duty,
                                             input int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - duty handshake bundle for pwm_gen (pol only with PWM_GEN_POLARITY_EN)
interface pwm_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;
`ifdef PWM_GEN_POLARITY_EN
  logic           pol;

  modport master (output duty_in, output duty_valid, output pol, input duty_ready);
  modport slave  (input duty_in, input duty_valid, input pol, output duty_ready);
`else
  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);
`endif
endinterface

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - free-running wrap counter with enable and terminal-count pulse
module pwm_counter #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic at_max;
  assign at_max = (count == WIDTH'(MAX_VALUE));

  // tc is qualified by en so a held counter never signals a period boundary.
  assign tc = en && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM generator with shadowed duty committed at terminal count; optional PWM_GEN_POLARITY_EN
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             tc,
  pwm_gen_if.slave         duty_bus,
  output logic             pwm_out,
  output logic             period_done,
  output logic             busy
);

  pwm_state_t     state;
  logic [WIDTH:0] shadow_duty;
  logic [WIDTH:0] active_duty;
  logic [WIDTH:0] duty_clamped;
  logic           transfer;
  logic           pol_q;
  logic           cmp;

  assign duty_clamped = (WIDTH+1)'(clamp_duty(32'(duty_bus.duty_in), MAX_VALUE + 1));
  assign duty_bus.duty_ready = (state == IDLE) || (state == RUN);
  assign transfer = duty_bus.duty_valid && duty_bus.duty_ready;
  assign busy = (state == PEND);

`ifdef PWM_GEN_POLARITY_EN
  logic pol_shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pol_shadow <= 1'b0;
      pol_q      <= 1'b0;
    end else if (transfer) begin
      pol_shadow <= duty_bus.pol;
    end else if (state == PEND && tc) begin
      pol_q <= pol_shadow;
    end
  end
`else
  assign pol_q = 1'b0;
`endif

  // A transfer coinciding with tc in RUN only loads the shadow; commit waits a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shadow_duty <= '0;
      active_duty <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (transfer) begin
            shadow_duty <= duty_clamped;
            state       <= PEND;
          end
        end
        PEND: begin
          if (tc) begin
            active_duty <= shadow_duty;
            state       <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp = ({1'b0, count} < active_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= cmp ^ pol_q;
      period_done <= tc;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - scoreboard bench: counter + pwm_gen against a period-level reference model
module tb_pwm_gen;

  localparam int W   = 4;
  localparam int MAX = 9;

  typedef struct {
    logic       pwm;
    logic       pd;
    logic       busy;
    logic       ready;
    logic [3:0] cnt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [W-1:0] count;
  logic         tc;
  logic         pwm_out;
  logic         period_done;
  logic         busy;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t exp_q[$];

  int m_cnt, m_active, m_shadow;
  bit m_pending;
  bit m_pol_shadow, m_pol_act;

  pwm_gen_if #(.WIDTH(W)) bus ();

  pwm_counter #(.WIDTH(W), .MAX_VALUE(MAX)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count),
    .tc    (tc)
  );

  pwm_gen #(.WIDTH(W), .MAX_VALUE(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .tc          (tc),
    .duty_bus    (bus.slave),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a period of MAX+1 counts; high for the first `duty` counts of each period.
  // A new duty is held pending and becomes the period's duty at the next boundary.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    bit   boundary;
    int   req;
    if (rst) begin
      m_cnt        = 0;
      m_active     = 0;
      m_shadow     = 0;
      m_pending    = 0;
      m_pol_shadow = 0;
      m_pol_act    = 0;
      exp_q.delete();
    end else begin
      boundary = en && (m_cnt == MAX);
      e.pwm    = (m_cnt < m_active) ^ m_pol_act;
      e.pd     = boundary;
      if (m_pending) begin
        if (boundary) begin
          m_active  = m_shadow;
          m_pol_act = m_pol_shadow;
          m_pending = 0;
        end
      end else if (bus.duty_valid) begin
        req       = int'(bus.duty_in);
        m_shadow  = (req > MAX + 1) ? MAX + 1 : req;
`ifdef PWM_GEN_POLARITY_EN
        m_pol_shadow = bus.pol;
`endif
        m_pending = 1;
      end
      e.busy  = m_pending;
      e.ready = !m_pending;
      if (en) m_cnt = (m_cnt + 1) % (MAX + 1);
      e.cnt = 4'(m_cnt);
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pwm_out",     int'(pwm_out),        int'(e.pwm));
      check("period_done", int'(period_done),    int'(e.pd));
      check("busy",        int'(busy),           int'(e.busy));
      check("duty_ready",  int'(bus.duty_ready), int'(e.ready));
      check("count",       int'(count),          int'(e.cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.duty_in = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic pulse(input int duty, input bit pol);
    bus.duty_valid = 1'b1;
    bus.duty_in    = 5'(duty);
`ifdef PWM_GEN_POLARITY_EN
    bus.pol = pol;
`else
    if (pol) bus.duty_valid = 1'b1;
`endif
    step(1);
    bus.duty_valid = 1'b0;
  endtask

  task automatic wait_count(input int c);
    int n = 0;
    while (count != 4'(c) && n < 50) begin
      step(1);
      n++;
    end
    check("wait_count", int'(count), c);
  endtask

  initial begin
    bus.duty_in    = '0;
    bus.duty_valid = 1'b0;
`ifdef PWM_GEN_POLARITY_EN
    bus.pol = 1'b0;
`endif
    #1;
    check("reset_pwm",   int'(pwm_out),        0);
    check("reset_pd",    int'(period_done),    0);
    check("reset_busy",  int'(busy),           0);
    check("reset_ready", int'(bus.duty_ready), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    step(30);

    wait_count(5);
    pulse(3, 1'b1);
    step(25);

    wait_count(9);
    pulse(7, 1'b0);
    step(30);

    wait_count(4);
    pulse(10, 1'b0);
    step(25);
    pulse(15, 1'b0);
    step(25);
    pulse(0, 1'b0);
    step(25);

    wait_count(3);
    pulse(6, 1'b0);
    step(2);
    en = 1'b0;
    step(8);
    en = 1'b1;
    step(25);

    wait_count(1);
    pulse(5, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("async_pwm",   int'(pwm_out),        0);
    check("async_pd",    int'(period_done),    0);
    check("async_busy",  int'(busy),           0);
    check("async_ready", int'(bus.duty_ready), 1);
    step(2);
    rst = 1'b0;
    step(25);

    repeat (400) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        pulse($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      end else begin
        step(1);
      end
    end
    en = 1'b1;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
